// File: rtl/tmds_pkg.sv
// TMDS serializer shared definitions: control-token codes and beat arithmetic.
package tmds_pkg;

   // Standard TMDS control-period codes (transmitted LSB first).
   localparam logic [9:0] TMDS_CTL0 = 10'b1101010100;
   localparam logic [9:0] TMDS_CTL1 = 10'b0010101011;
   localparam logic [9:0] TMDS_CTL2 = 10'b0101010100;
   localparam logic [9:0] TMDS_CTL3 = 10'b1010101011;

   // Number of clk cycles needed to emit one token through a lane_w-bit lane.
   function automatic int lane_beats(input int token_w, input int lane_w);
      return token_w / lane_w;
   endfunction

endpackage

// File: rtl/tmds_lane_shifter.sv
// One TMDS channel: parallel-load shift register emitting LANE_W bits per clk, LSB first.
module tmds_lane_shifter #(
   parameter int TOKEN_W = 10,
   parameter int LANE_W  = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic [TOKEN_W-1:0] load_data,
   input  logic               shift,
   output logic [LANE_W-1:0]  lane_out
);

   logic [TOKEN_W-1:0] sh_q;
   logic [TOKEN_W-1:0] sh_d;

   // Next shift-register content: load a fresh token or advance by one beat.
   always_comb begin
      sh_d = sh_q;
      if (load) begin
         sh_d = load_data;
      end else if (shift) begin
         sh_d = sh_q >> LANE_W;
      end
   end

   // Shift-register state; cleared on reset so the pad idles at zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         sh_q <= '0;
      end else begin
         sh_q <= sh_d;
      end
   end

   // Lane driven straight from the flops, no output logic.
   assign lane_out = sh_q[LANE_W-1:0];

endmodule

// File: rtl/tmds_gearbox_serializer.sv
// Bit-clock TMDS serializer: one-deep hold slot, bypass load, idle-token underflow fill.
module tmds_gearbox_serializer
   import tmds_pkg::*;
#(
   parameter int                 CHANNELS   = 3,
   parameter int                 TOKEN_W    = 10,
   parameter int                 LANE_W     = 2,
   parameter logic [TOKEN_W-1:0] IDLE_TOKEN = TOKEN_W'(TMDS_CTL0),
   parameter int                 CNT_W      = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [CHANNELS*TOKEN_W-1:0]  in_tokens,
   output logic [CHANNELS*LANE_W-1:0]   lane_out,
   output logic                         frame_start,
   output logic                         underflow,
   output logic [CNT_W-1:0]             underflow_cnt
);

   localparam int BEATS = lane_beats(TOKEN_W, LANE_W);
   localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int BUS_W = CHANNELS * TOKEN_W;
   localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS - 1);

   if ((TOKEN_W % LANE_W) != 0) begin : g_bad_lane_w
      $error("TOKEN_W must be a multiple of LANE_W");
   end

   logic [BCW-1:0]   beat_cnt_q, beat_cnt_d;
   logic [BUS_W-1:0] hold_q, hold_d;
   logic             hold_valid_q, hold_valid_d;
   logic             primed_q, primed_d;
   logic             underflow_q, underflow_d;
   logic [CNT_W-1:0] underflow_cnt_q, underflow_cnt_d;
   logic             frame_start_q, frame_start_d;

   logic             load_edge;
   logic             accept;
   logic [BUS_W-1:0] shift_src;

   assign load_edge = (beat_cnt_q == LAST_BEAT);
   assign in_ready  = !hold_valid_q || load_edge;
   assign accept    = in_valid && in_ready;

   // Next-state for beat counter, hold slot, load source and underflow tracking.
   always_comb begin
      beat_cnt_d = load_edge ? '0 : beat_cnt_q + BCW'(1);

      // Hold slot fills on any accept that cannot go straight to the shifters;
      // a load edge with nothing new drains it.
      hold_d       = hold_q;
      hold_valid_d = hold_valid_q;
      if (accept && (!load_edge || hold_valid_q)) begin
         hold_d       = in_tokens;
         hold_valid_d = 1'b1;
      end else if (load_edge) begin
         hold_valid_d = 1'b0;
      end

      // Older held token wins over the live input; idle only when both are empty.
      if (hold_valid_q) begin
         shift_src = hold_q;
      end else if (in_valid) begin
         shift_src = in_tokens;
      end else begin
         shift_src = {CHANNELS{IDLE_TOKEN}};
      end

      // Idle fill before the first real token is expected and stays silent.
      underflow_d     = load_edge && !hold_valid_q && !in_valid && primed_q;
      underflow_cnt_d = underflow_cnt_q;
      if (underflow_d && (underflow_cnt_q != '1)) begin
         underflow_cnt_d = underflow_cnt_q + CNT_W'(1);
      end

      primed_d      = primed_q || accept;
      frame_start_d = load_edge;
   end

   // Control state; reset makes the first edge after release a load edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         beat_cnt_q      <= LAST_BEAT;
         hold_valid_q    <= 1'b0;
         primed_q        <= 1'b0;
         underflow_q     <= 1'b0;
         underflow_cnt_q <= '0;
         frame_start_q   <= 1'b0;
      end else begin
         beat_cnt_q      <= beat_cnt_d;
         hold_valid_q    <= hold_valid_d;
         primed_q        <= primed_d;
         underflow_q     <= underflow_d;
         underflow_cnt_q <= underflow_cnt_d;
         frame_start_q   <= frame_start_d;
      end
   end

   // Hold data is qualified by hold_valid_q, so it needs no reset.
   always_ff @(posedge clk) begin
      hold_q <= hold_d;
   end

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      tmds_lane_shifter #(
         .TOKEN_W (TOKEN_W),
         .LANE_W  (LANE_W)
      ) u_shifter (
         .clk       (clk),
         .rst       (rst),
         .load      (load_edge),
         .load_data (shift_src[c*TOKEN_W +: TOKEN_W]),
         .shift     (!load_edge),
         .lane_out  (lane_out[c*LANE_W +: LANE_W])
      );
   end

   assign frame_start   = frame_start_q;
   assign underflow     = underflow_q;
   assign underflow_cnt = underflow_cnt_q;

endmodule
